// File: rtl/riscv_regfile_pkg.sv
// Shared types and default parameters for the scoreboarded register file.
// Holds the two-state clear/run FSM encoding.
package riscv_regfile_pkg;

   localparam int unsigned XlenDefault    = 32;
   localparam int unsigned NregsDefault   = 32;
   localparam int unsigned NreadDefault   = 2;
   localparam int unsigned BypassDefault  = 1;
   localparam int unsigned ZeroRegDefault = 1;

   typedef enum logic [0:0] {
      StClear = 1'b0,
      StRun   = 1'b1
   } state_e;

endpackage

// File: rtl/riscv_regfile_sb_scoreboard.sv
// Pending-writeback scoreboard: one busy bit per register, with set/clear priority
// and an independent busy lookup for each read port.
module riscv_scoreboard
   import riscv_regfile_pkg::*;
#(
   parameter int unsigned NREGS    = NregsDefault,
   parameter int unsigned NREAD    = NreadDefault,
   parameter int unsigned ZERO_REG = ZeroRegDefault,
   localparam int unsigned AW      = $clog2(NREGS)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     set_i,
   input  logic [AW-1:0]            set_addr_i,
   input  logic                     clr_i,
   input  logic [AW-1:0]            clr_addr_i,
   input  logic [NREAD-1:0][AW-1:0] rd_addr_i,
   output logic [NREAD-1:0]         rd_busy_o
);

   logic [NREGS-1:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr_i) begin
         busy_d[clr_addr_i] = 1'b0;
      end
      // Applied after the clear so a same-index reservation wins.
      if (set_i) begin
         busy_d[set_addr_i] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_comb begin
      rd_busy_o = '0;
      for (int p = 0; p < NREAD; p++) begin
         rd_busy_o[p] = busy_q[rd_addr_i[p]];
      end
   end

endmodule

// File: rtl/riscv_regfile_sb.sv
// Register file with a post-reset zero sweep, optional write-to-read bypass and a
// busy scoreboard tracking registers with an outstanding writeback.
module riscv_regfile_sb
   import riscv_regfile_pkg::*;
#(
   parameter int unsigned XLEN     = XlenDefault,
   parameter int unsigned NREGS    = NregsDefault,
   parameter int unsigned NREAD    = NreadDefault,
   parameter int unsigned BYPASS   = BypassDefault,
   parameter int unsigned ZERO_REG = ZeroRegDefault,
   localparam int unsigned AW      = $clog2(NREGS)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       w_enable_i,
   input  logic [AW-1:0]              w_addr_i,
   input  logic [XLEN-1:0]            w_data_i,
   input  logic                       rsv_enable_i,
   input  logic [AW-1:0]              rsv_addr_i,
   input  logic [NREAD-1:0][AW-1:0]   rd_addr_i,
   output logic [NREAD-1:0][XLEN-1:0] rd_data_o,
   output logic [NREAD-1:0]           rd_busy_o,
   output logic                       ready_o
);

   state_e          state_q, state_d;
   logic [AW-1:0]   sweep_q, sweep_d;
   logic            ready_q;
   logic [XLEN-1:0] mem_q [NREGS];
   logic [XLEN-1:0] mem_d [NREGS];

   logic             run;
   logic             w_ok;
   logic             rsv_ok;
   logic [NREAD-1:0] sb_busy;

   assign run    = (state_q == StRun);
   assign w_ok   = run && w_enable_i && !((ZERO_REG != 0) && (w_addr_i == '0));
   assign rsv_ok = run && rsv_enable_i;

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      unique case (state_q)
         StClear: begin
            sweep_d = sweep_q + AW'(1);
            if (sweep_q == AW'(NREGS - 1)) begin
               state_d = StRun;
            end
         end
         StRun: begin
            sweep_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StClear;
         sweep_q <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         ready_q <= (state_d == StRun);
      end
   end

   assign ready_o = ready_q;

   // Storage is not reset; the sweep alone defines its contents.
   always_comb begin
      mem_d = mem_q;
      if (state_q == StClear) begin
         mem_d[sweep_q] = '0;
      end else if (w_ok) begin
         mem_d[w_addr_i] = w_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   riscv_scoreboard #(
      .NREGS   (NREGS),
      .NREAD   (NREAD),
      .ZERO_REG(ZERO_REG)
   ) u_scoreboard (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .set_i     (rsv_ok),
      .set_addr_i(rsv_addr_i),
      .clr_i     (w_ok),
      .clr_addr_i(w_addr_i),
      .rd_addr_i (rd_addr_i),
      .rd_busy_o (sb_busy)
   );

   always_comb begin
      rd_data_o = '0;
      rd_busy_o = '0;
      for (int p = 0; p < NREAD; p++) begin
         rd_data_o[p] = mem_q[rd_addr_i[p]];
         rd_busy_o[p] = sb_busy[p];
         if ((BYPASS != 0) && w_ok && (rd_addr_i[p] == w_addr_i)) begin
            rd_data_o[p] = w_data_i;
            rd_busy_o[p] = 1'b0;
         end
         if (!run || ((ZERO_REG != 0) && (rd_addr_i[p] == '0))) begin
            rd_data_o[p] = '0;
            rd_busy_o[p] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Directed bench for riscv_regfile_sb: a bypassing and a non-bypassing instance
// share one stimulus stream and are checked against hand-computed values.
module tb_riscv_regfile_sb;

   logic            clk;
   logic            rst;
   logic            w_en;
   logic [4:0]      w_addr;
   logic [31:0]     w_data;
   logic            rsv_en;
   logic [4:0]      rsv_addr;
   logic [1:0][4:0] rd_addr;

   logic [1:0][31:0] rd_data_b, rd_data_n;
   logic [1:0]       rd_busy_b, rd_busy_n;
   logic             ready_b, ready_n;

   int checks = 0;
   int errors = 0;

   riscv_regfile_sb #(
      .BYPASS(1)
   ) u_dut_byp (
      .clk_i       (clk),
      .rst_i       (rst),
      .w_enable_i  (w_en),
      .w_addr_i    (w_addr),
      .w_data_i    (w_data),
      .rsv_enable_i(rsv_en),
      .rsv_addr_i  (rsv_addr),
      .rd_addr_i   (rd_addr),
      .rd_data_o   (rd_data_b),
      .rd_busy_o   (rd_busy_b),
      .ready_o     (ready_b)
   );

   riscv_regfile_sb #(
      .BYPASS(0)
   ) u_dut_nobyp (
      .clk_i       (clk),
      .rst_i       (rst),
      .w_enable_i  (w_en),
      .w_addr_i    (w_addr),
      .w_data_i    (w_data),
      .rsv_enable_i(rsv_en),
      .rsv_addr_i  (rsv_addr),
      .rd_addr_i   (rd_addr),
      .rd_data_o   (rd_data_n),
      .rd_busy_o   (rd_busy_n),
      .ready_o     (ready_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle;
      w_en   = 1'b0;
      rsv_en = 1'b0;
   endtask

   // Checks the 32-cycle clear window that follows a reset release.
   task automatic check_sweep(input string tag);
      for (int i = 0; i < 32; i++) begin
         #1;
         check({tag, " ready_b low"}, {31'd0, ready_b}, 32'd0);
         check({tag, " ready_n low"}, {31'd0, ready_n}, 32'd0);
         check({tag, " data low"}, rd_data_b[1], 32'd0);
         tick();
      end
      #1;
      check({tag, " ready_b high"}, {31'd0, ready_b}, 32'd1);
      check({tag, " ready_n high"}, {31'd0, ready_n}, 32'd1);
   endtask

   initial begin
      rst      = 1'b1;
      w_en     = 1'b0;
      w_addr   = '0;
      w_data   = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
      rd_addr  = '0;
      tick();
      #1;
      check("reset ready", {31'd0, ready_b}, 32'd0);
      check("reset busy", {30'd0, rd_busy_b}, 32'd0);
      tick();
      rst = 1'b0;

      // Clear window; on its last cycle a write and a reservation must be ignored.
      rd_addr[0] = 5'd4;
      rd_addr[1] = 5'd4;
      for (int i = 0; i < 32; i++) begin
         if (i == 31) begin
            w_en     = 1'b1;
            w_addr   = 5'd4;
            w_data   = 32'hAAAA_5555;
            rsv_en   = 1'b1;
            rsv_addr = 5'd4;
         end
         #1;
         check("clear ready", {31'd0, ready_b}, 32'd0);
         check("clear data", rd_data_b[0], 32'd0);
         check("clear busy", {30'd0, rd_busy_b}, 32'd0);
         tick();
      end
      idle();
      #1;
      check("ready at 32", {31'd0, ready_b}, 32'd1);
      check("x4 write ignored", rd_data_b[0], 32'd0);
      check("x4 rsv ignored", {31'd0, rd_busy_b[0]}, 32'd0);

      // Same-cycle write of x5 with bypass on and off.
      w_en       = 1'b1;
      w_addr     = 5'd5;
      w_data     = 32'hDEAD_BEEF;
      rd_addr[0] = 5'd5;
      rd_addr[1] = 5'd5;
      #1;
      check("x5 bypass", rd_data_b[1], 32'hDEAD_BEEF);
      check("x5 no bypass", rd_data_n[1], 32'd0);
      tick();
      idle();
      #1;
      check("x5 stored byp", rd_data_b[1], 32'hDEAD_BEEF);
      check("x5 stored nobyp", rd_data_n[1], 32'hDEAD_BEEF);
      check("x5 port0", rd_data_b[0], 32'hDEAD_BEEF);
      check("x5 not busy", {30'd0, rd_busy_b}, 32'd0);

      // Reserve x7, hold three cycles, then write it back.
      rsv_en     = 1'b1;
      rsv_addr   = 5'd7;
      rd_addr[0] = 5'd7;
      #1;
      check("x7 rsv cycle", {31'd0, rd_busy_b[0]}, 32'd0);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         #1;
         check("x7 pending", {31'd0, rd_busy_b[0]}, 32'd1);
         check("x7 port1 x5", {31'd0, rd_busy_b[1]}, 32'd0);
         tick();
      end
      w_en   = 1'b1;
      w_addr = 5'd7;
      w_data = 32'h0000_1234;
      #1;
      check("x7 wb busy byp", {31'd0, rd_busy_b[0]}, 32'd0);
      check("x7 wb busy nobyp", {31'd0, rd_busy_n[0]}, 32'd1);
      check("x7 wb data byp", rd_data_b[0], 32'h0000_1234);
      tick();
      idle();
      #1;
      check("x7 done busy", {31'd0, rd_busy_n[0]}, 32'd0);
      check("x7 stored", rd_data_n[0], 32'h0000_1234);
      check("ports distinct", rd_data_b[1], 32'hDEAD_BEEF);

      // Reservation and write to x9 together: reservation wins.
      w_en       = 1'b1;
      w_addr     = 5'd9;
      w_data     = 32'h0000_0099;
      rsv_en     = 1'b1;
      rsv_addr   = 5'd9;
      rd_addr[1] = 5'd9;
      tick();
      idle();
      #1;
      check("x9 busy", {31'd0, rd_busy_b[1]}, 32'd1);
      check("x9 data", rd_data_b[1], 32'h0000_0099);

      // Writes and reservations of x0 are dropped.
      w_en       = 1'b1;
      w_addr     = 5'd0;
      w_data     = 32'hFFFF_FFFF;
      rsv_en     = 1'b1;
      rsv_addr   = 5'd0;
      rd_addr[0] = 5'd0;
      rd_addr[1] = 5'd0;
      #1;
      check("x0 same data", rd_data_b[0], 32'd0);
      check("x0 same busy", {30'd0, rd_busy_b}, 32'd0);
      tick();
      idle();
      #1;
      check("x0 data p0", rd_data_b[0], 32'd0);
      check("x0 data p1", rd_data_n[1], 32'd0);
      check("x0 busy", {30'd0, rd_busy_n}, 32'd0);

      // Write x3 and reserve x12, then reset twice with a restart mid-sweep.
      w_en       = 1'b1;
      w_addr     = 5'd3;
      w_data     = 32'h0000_0055;
      rsv_en     = 1'b1;
      rsv_addr   = 5'd12;
      rd_addr[0] = 5'd3;
      rd_addr[1] = 5'd12;
      tick();
      idle();
      #1;
      check("x3 stored", rd_data_b[0], 32'h0000_0055);
      check("x12 busy", {31'd0, rd_busy_b[1]}, 32'd1);
      rst = 1'b1;
      tick();
      #1;
      check("rst ready low", {31'd0, ready_b}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_sweep("restart");
      check("x3 cleared", rd_data_b[0], 32'd0);
      check("x12 cleared", {31'd0, rd_busy_b[1]}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
